// File: rtl/iso14443a_pkg.sv
// Shared ISO/IEC 14443-3A Tx-path definitions.
package iso14443a_pkg;

    localparam int unsigned FRAME_ENCODE_STATE_W = 3;

    typedef enum logic [FRAME_ENCODE_STATE_W-1:0] {
        FE_IDLE   = 3'd0,
        FE_SOC    = 3'd1,
        FE_DATA   = 3'd2,
        FE_PARITY = 3'd3,
        FE_EOC    = 3'd4
    } frame_encode_state_t;

    // Start-of-communication bit value.
    localparam logic SOC_BIT_VALUE   = 1'b1;
    // Parity seed for every byte after the first: plain odd parity.
    localparam logic PARITY_SEED_ODD = 1'b1;

endpackage

// File: rtl/frame_encode.sv
// PICC frame builder: SOC, data bits LSB first, odd parity per byte, EOC.
// Symbol outputs are decoded from state, so the encoder sees the next
// symbol in the same cycle the state changes.
module frame_encode
    import iso14443a_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_data,
    input  logic in_data_valid,
    input  logic in_last_bit_in_byte,
    output logic in_req,
    input  logic parity_init,
    output logic out_data,
    output logic out_data_valid,
    output logic out_eoc,
    input  logic out_req
);

    frame_encode_state_t state_q;
    frame_encode_state_t state_d;
    logic                parity_q;
    logic                parity_d;
    logic                in_req_q;
    logic                in_req_d;

    // State, running parity and serialiser advance pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FE_IDLE;
            parity_q <= PARITY_SEED_ODD;
            in_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            in_req_q <= in_req_d;
        end
    end

    // Next-state, parity update and symbol decode.
    always_comb begin
        state_d        = state_q;
        parity_d       = parity_q;
        in_req_d       = 1'b0;
        out_data       = 1'b0;
        out_data_valid = 1'b0;
        out_eoc        = 1'b0;

        case (state_q)
            FE_IDLE: begin
                if (in_data_valid) begin
                    state_d  = FE_SOC;
                    parity_d = parity_init;
                end
            end

            FE_SOC: begin
                out_data       = SOC_BIT_VALUE;
                out_data_valid = 1'b1;
                if (out_req) begin
                    state_d = FE_DATA;
                end
            end

            FE_DATA: begin
                out_data       = in_data;
                out_data_valid = 1'b1;
                // A serialiser abort mid-byte closes the frame without parity.
                if (!in_data_valid) begin
                    state_d = FE_EOC;
                end else if (out_req) begin
                    in_req_d = 1'b1;
                    parity_d = parity_q ^ in_data;
                    if (in_last_bit_in_byte) begin
                        state_d = FE_PARITY;
                    end
                end
            end

            FE_PARITY: begin
                out_data       = parity_q;
                out_data_valid = 1'b1;
                if (out_req) begin
                    parity_d = PARITY_SEED_ODD;
                    state_d  = in_data_valid ? FE_DATA : FE_EOC;
                end
            end

            FE_EOC: begin
                out_data_valid = 1'b1;
                out_eoc        = 1'b1;
                if (out_req) begin
                    state_d = FE_IDLE;
                end
            end

            default: begin
                state_d = FE_IDLE;
            end
        endcase
    end

    assign in_req = in_req_q;

endmodule

// File: tb/tb_frame_encode.sv
// Self-checking bench for frame_encode with a behavioural serialiser and
// a frame-level reference model.
module tb_frame_encode;

    logic clk;
    logic rst_n;
    logic in_data;
    logic in_data_valid;
    logic in_last_bit_in_byte;
    logic in_req;
    logic parity_init;
    logic out_data;
    logic out_data_valid;
    logic out_eoc;
    logic out_req;

    frame_encode dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_data             (in_data),
        .in_data_valid       (in_data_valid),
        .in_last_bit_in_byte (in_last_bit_in_byte),
        .in_req              (in_req),
        .parity_init         (parity_init),
        .out_data            (out_data),
        .out_data_valid      (out_data_valid),
        .out_eoc             (out_eoc),
        .out_req             (out_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Serialiser content and expected symbol stream ({eoc, data}).
    bit         ser_bits[$];
    bit         ser_last[$];
    logic [1:0] exp_q[$];
    logic [1:0] cap_q[$];
    bit         p_run;

    int ptr;
    int inreq_cnt;
    int budget;
    bit prev_inreq;
    bit consec;
    bit stall_bad;
    bit soc_bad;
    bit timeout;

    task automatic frame_begin(input bit seed);
        ser_bits.delete();
        ser_last.delete();
        exp_q.delete();
        p_run = seed;
        exp_q.push_back(2'b01);
    endtask

    // Append nb bits of v LSB first; a full byte carries a parity bit chosen
    // so that seed-adjusted count of ones is odd.
    task automatic frame_byte(input logic [7:0] v, input int nb, input bit full);
        int ones;
        ones = 0;
        for (int i = 0; i < nb; i++) begin
            ser_bits.push_back(v[i]);
            ser_last.push_back(full && (i == nb - 1));
            exp_q.push_back({1'b0, v[i]});
            if (v[i]) ones++;
        end
        if (full) begin
            exp_q.push_back({1'b0, ((ones % 2) == 0) ? p_run : ~p_run});
            p_run = 1'b1;
        end
    endtask

    task automatic frame_end();
        exp_q.push_back(2'b10);
    endtask

    task automatic ser_drive();
        if (ptr < ser_bits.size()) begin
            in_data             = ser_bits[ptr];
            in_last_bit_in_byte = ser_last[ptr];
            in_data_valid       = 1'b1;
        end else begin
            in_data             = 1'b0;
            in_last_bit_in_byte = 1'b0;
            in_data_valid       = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        budget--;
        if (in_req === 1'b1) begin
            inreq_cnt++;
            if (prev_inreq) consec = 1'b1;
            ptr++;
            ser_drive();
        end
        prev_inreq = (in_req === 1'b1);
    endtask

    // Play the prepared frame, consuming symbols like the bit encoder.
    task automatic run_frame(input bit seed, input int stop_after, input int stall_at);
        int  got;
        int  gap;
        bit  done;
        logic hold;
        ptr = 0; inreq_cnt = 0; prev_inreq = 1'b0; consec = 1'b0;
        stall_bad = 1'b0; soc_bad = 1'b0; timeout = 1'b0;
        budget = 20000;
        cap_q.delete();
        parity_init = seed;
        ser_drive();
        tick();
        if (!(out_data_valid === 1'b1 && out_data === 1'b1 && out_eoc === 1'b0)) soc_bad = 1'b1;
        got = 0;
        done = 1'b0;
        while (!done) begin
            gap = $urandom_range(3, 1);
            for (int g = 0; g < gap; g++) tick();
            if (got == stall_at) begin
                hold = out_data;
                for (int s = 0; s < 500; s++) begin
                    tick();
                    if (out_data !== hold || in_req !== 1'b0 || out_data_valid !== 1'b1)
                        stall_bad = 1'b1;
                end
            end
            if (out_data_valid !== 1'b1) begin
                timeout = 1'b1;
                done = 1'b1;
            end else begin
                cap_q.push_back({out_eoc, out_data});
                got++;
                out_req = 1'b1;
                tick();
                out_req = 1'b0;
                if (cap_q[cap_q.size() - 1] == 2'b10) done = 1'b1;
                if (got == stop_after) done = 1'b1;
            end
            if (budget <= 0) begin
                timeout = 1'b1;
                done = 1'b1;
            end
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (cap_q[i] !== exp_q[i]) return i;
        end
        if (cap_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_data = 1'b0; in_data_valid = 1'b0; in_last_bit_in_byte = 1'b0;
        parity_init = 1'b1; out_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_data_valid, out_eoc, out_data, in_req} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0000", {out_data_valid, out_eoc, out_data, in_req});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (out_data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_valid: got %b want 0", out_data_valid);
        end
    endtask

    task automatic test_idle_out_req();
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_req = 1'b1;
            tick();
            out_req = 1'b0;
            tick();
            if (out_data_valid !== 1'b0 || in_req !== 1'b0 || out_eoc !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL idle_out_req: got activity=1 want 0");
        end
    endtask

    task automatic test_single_byte();
        int d;
        frame_begin(1'b1);
        frame_byte(8'h26, 8, 1'b1);
        frame_end();
        run_frame(1'b1, 0, -1);
        d = first_diff();
        n_cmp++;
        if (d != -1 || timeout) begin
            n_err++;
            $display("FAIL single_stream: got len %0d diff@%0d want len %0d", cap_q.size(), d, exp_q.size());
        end
        n_cmp++;
        if (cap_q.size() != 11 || cap_q[9] !== 2'b00 || cap_q[10] !== 2'b10) begin
            n_err++;
            $display("FAIL single_parity_eoc: got len %0d want len 11 parity 00 eoc 10", cap_q.size());
        end
        n_cmp++;
        if (inreq_cnt != 8 || consec || soc_bad) begin
            n_err++;
            $display("FAIL single_in_req: got %0d consec %0d soc_bad %0d want 8 0 0", inreq_cnt, consec, soc_bad);
        end
        tick();
        n_cmp++;
        if (out_data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_back_idle: got %b want 0", out_data_valid);
        end
    endtask

    task automatic test_two_bytes();
        int d;
        frame_begin(1'b1);
        frame_byte(8'h00, 8, 1'b1);
        frame_byte(8'hFF, 8, 1'b1);
        frame_end();
        run_frame(1'b1, 0, -1);
        d = first_diff();
        n_cmp++;
        if (d != -1 || timeout) begin
            n_err++;
            $display("FAIL two_stream: got len %0d diff@%0d want len %0d", cap_q.size(), d, exp_q.size());
        end
        n_cmp++;
        if (cap_q.size() != 20 || cap_q[9] !== 2'b01 || cap_q[18] !== 2'b01) begin
            n_err++;
            $display("FAIL two_parity: got len %0d want len 20 parities 01 01", cap_q.size());
        end
        n_cmp++;
        if (inreq_cnt != 16 || consec) begin
            n_err++;
            $display("FAIL two_in_req: got %0d consec %0d want 16 0", inreq_cnt, consec);
        end
    endtask

    task automatic test_split_byte();
        int d;
        frame_begin(1'b0);
        frame_byte(8'h05, 3, 1'b1);
        frame_byte(8'h5A, 8, 1'b1);
        frame_end();
        run_frame(1'b0, 0, -1);
        d = first_diff();
        n_cmp++;
        if (d != -1 || timeout) begin
            n_err++;
            $display("FAIL split_stream: got len %0d diff@%0d want len %0d", cap_q.size(), d, exp_q.size());
        end
        n_cmp++;
        if (cap_q.size() != 15 || cap_q[4] !== 2'b00 || cap_q[13] !== 2'b01) begin
            n_err++;
            $display("FAIL split_parity: got len %0d want len 15 parities 00 01", cap_q.size());
        end
    endtask

    task automatic test_abort();
        int d;
        frame_begin(1'b1);
        frame_byte(8'hA7, 8, 1'b1);
        frame_byte(8'h0D, 4, 1'b0);
        frame_end();
        run_frame(1'b1, 0, -1);
        d = first_diff();
        n_cmp++;
        if (d != -1 || timeout || cap_q.size() != 15) begin
            n_err++;
            $display("FAIL abort_stream: got len %0d diff@%0d want len 15", cap_q.size(), d);
        end
        n_cmp++;
        if (inreq_cnt != 12) begin
            n_err++;
            $display("FAIL abort_in_req: got %0d want 12", inreq_cnt);
        end
        tick();
        n_cmp++;
        if (out_data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_back_idle: got %b want 0", out_data_valid);
        end
    endtask

    task automatic test_reset_in_parity();
        int d;
        frame_begin(1'b1);
        frame_byte(8'($urandom), 8, 1'b1);
        frame_end();
        run_frame(1'b1, 9, -1);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_data_valid, out_eoc, out_data, in_req} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %b want 0000", {out_data_valid, out_eoc, out_data, in_req});
        end
        in_data_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        frame_begin(1'b0);
        frame_byte(8'($urandom), 8, 1'b1);
        frame_byte(8'($urandom), 8, 1'b1);
        frame_end();
        run_frame(1'b0, 0, -1);
        d = first_diff();
        n_cmp++;
        if (d != -1 || timeout || soc_bad) begin
            n_err++;
            $display("FAIL reset_mid_new_frame: got len %0d diff@%0d soc_bad %0d want len %0d", cap_q.size(), d, soc_bad, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int d;
        frame_begin(1'b1);
        frame_byte(8'($urandom), 8, 1'b1);
        frame_end();
        run_frame(1'b1, 0, 3);
        n_cmp++;
        if (stall_bad) begin
            n_err++;
            $display("FAIL stall_hold: got disturbed=1 want 0");
        end
        d = first_diff();
        n_cmp++;
        if (d != -1 || timeout) begin
            n_err++;
            $display("FAIL stall_stream: got len %0d diff@%0d want len %0d", cap_q.size(), d, exp_q.size());
        end
    endtask

    task automatic test_random();
        int  d;
        int  nbytes;
        int  nb;
        int  nbits;
        bit  seed;
        bit  abort;
        for (int f = 0; f < 20; f++) begin
            seed   = 1'($urandom_range(1, 0));
            nbytes = $urandom_range(4, 1);
            abort  = ($urandom_range(3, 0) == 0);
            frame_begin(seed);
            nbits = 0;
            for (int b = 0; b < nbytes; b++) begin
                nb = (b == 0 && !seed) ? $urandom_range(7, 1) : 8;
                if (abort && b == nbytes - 1 && !(b == 0 && !seed)) begin
                    nb = $urandom_range(7, 1);
                    frame_byte(8'($urandom), nb, 1'b0);
                end else begin
                    frame_byte(8'($urandom), nb, 1'b1);
                end
                nbits += nb;
            end
            frame_end();
            run_frame(seed, 0, -1);
            d = first_diff();
            n_cmp++;
            if (d != -1 || timeout || soc_bad) begin
                n_err++;
                $display("FAIL random_stream[%0d]: got len %0d diff@%0d want len %0d", f, cap_q.size(), d, exp_q.size());
            end
            n_cmp++;
            if (inreq_cnt != nbits || consec) begin
                n_err++;
                $display("FAIL random_in_req[%0d]: got %0d consec %0d want %0d 0", f, inreq_cnt, consec, nbits);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_idle_out_req();
        test_single_byte();
        test_two_bytes();
        test_split_byte();
        test_abort();
        test_reset_in_parity();
        test_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_encode.md
# frame_encode

Tx-path framing stage sitting directly downstream of the byte-to-bit serialiser and upstream of the bit/subcarrier encoder. Pulls data bits from the serialiser and wraps them into an ISO/IEC 14443-3A PICC frame: start-of-communication bit, data bits LSB first, an odd parity bit after every byte, then an end-of-communication marker. Downstream sees one uniform bit stream and needs no knowledge of bytes or parity.

## Interface
Parameters: none.

Ports:
- clk  input  1  13.56 MHz clock
- rst_n  input  1  reset; one clock, asynchronous, active-low (synchronised deassertion provided externally)
- in_data  input  1  current data bit from serialiser
- in_data_valid  input  1  serialiser has a bit / frame in progress
- in_last_bit_in_byte  input  1  in_data is the final bit of its byte
- in_req  output  1  one-tick pulse: advance serialiser to next bit
- parity_init  input  1  parity seed for the first byte, sampled on frame start (1 = normal odd parity; split anticollision byte: 1 XOR reader-sent bits)
- out_data  output  1  bit to encode
- out_data_valid  output  1  out_data is meaningful
- out_eoc  output  1  current symbol is end-of-communication (out_data then 0)
- out_req  input  1  one-tick pulse from bit encoder: current symbol consumed, present next

## Operation
- States: IDLE, SOC, DATA, PARITY, EOC.
- IDLE: out_data_valid=0. On in_data_valid=1 -> SOC; parity <= parity_init.
- SOC: out_data=1, out_data_valid=1. On out_req -> DATA.
- DATA: out_data=in_data. On out_req: pulse in_req next cycle; parity <= parity ^ in_data; if in_last_bit_in_byte -> PARITY else stay DATA.
- PARITY: out_data=parity. On out_req: parity <= 1; if in_data_valid -> DATA else EOC.
- EOC: out_data=0, out_eoc=1, out_data_valid=1. On out_req -> IDLE.
- Error: in_data_valid=0 while in DATA (serialiser aborted mid-byte) -> EOC immediately, no parity bit sent.
- Parity is odd over the 8 bits of each full byte (seed 1); only the first byte may use a non-1 seed.
- out_req in IDLE is ignored.

## Timing
- Reset values: state IDLE, out_data_valid 0, out_eoc 0, out_data 0, in_req 0, parity 1.
- in_data_valid rising at cycle N -> out_data_valid=1 with SOC at N+1.
- in_req is registered: high exactly in the cycle after the out_req that consumed a DATA bit, never otherwise, never two consecutive cycles.
- out_data/out_eoc/out_data_valid are combinational from state, parity and in_data only (no out_req path).
- out_req pulses are guaranteed ≥2 cycles apart (a bit period is 128 cycles); serialiser output is therefore settled before the next DATA bit is presented, and in_data_valid is settled by the time PARITY is consumed.
- State transition takes effect the cycle after out_req.
- Reset mid-frame: immediate return to IDLE, outputs to reset values; no EOC emitted.

## Structure
- Shared package iso14443a_pkg: frame_encode_state_t enum, SOC_BIT_VALUE (1), PARITY_SEED_ODD (1).
- Single module, no sub-modules; parity is one flop updated in place.

## Test plan
- Single byte 0x26, parity_init=1: stream = 1, 0,1,1,0,0,1,0,0, parity 0, then EOC with out_eoc=1; exactly 8 in_req pulses.
- Two bytes 0x00, 0xFF: parity after 0x00 is 1, after 0xFF is 1; frame length 1+9+9 bits + EOC.
- Split first byte of 3 bits 0b101 with parity_init=0, then 0x5A: parity after 3 bits = 0^1^0^1 = 0, then 0x5A with parity 1.
- Serialiser drops in_data_valid after 4 bits of a byte: next symbol is EOC, no parity, back to IDLE after out_req.
- rst_n asserted while in PARITY: outputs at reset values immediately; new frame after reset starts with SOC and parity seeded from parity_init.
- out_req held low for 500 cycles in DATA: out_data stable, no in_req, no state change.
